// File: rtl/seg7_scan_driver_if.sv
// Host/display bundle for the 8-digit multiplexed 7-segment scan driver.
// The host (master) supplies the value, strobe and decimal points; the driver (slave) returns status and pins.
interface seg7_scan_driver_if;
    logic [31:0] data_in;
    logic        load;
    logic        enable;
    logic [7:0]  dp_in;
    logic        pending;
    logic        frame_tick;
    logic [7:0]  Anode_Activate;
    logic [6:0]  LED_out;
    logic        seg_dp;

    modport master (
        output data_in, load, enable, dp_in,
        input  pending, frame_tick, Anode_Activate, LED_out, seg_dp
    );

    modport slave (
        input  data_in, load, enable, dp_in,
        output pending, frame_tick, Anode_Activate, LED_out, seg_dp
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned value commit,
// leading-zero blanking and per-digit decimal points. All pin outputs are registered.
module seg7_scan_driver #(
    parameter int DIV_MAX  = 100000,
    parameter int DIGITS   = 8,
    parameter int BLANK_LZ = 1
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam int               DIV_W      = 20;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV_MAX - 1);
    localparam logic [2:0]       DIGIT_LAST = 3'(DIGITS - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [2:0]       digit_idx_reg;
    logic [31:0]      shown_val_reg;
    logic [31:0]      pend_val_reg;
    logic             pending_reg;
    logic [7:0]       anode_reg;
    logic [6:0]       led_reg;
    logic             dp_reg;

    logic             adv;
    logic             boundary;
    logic [7:0]       nib_nz;
    logic [7:0]       blank_vec;
    logic [3:0]       cur_nib;
    logic             cur_blank;

    assign adv      = bus.enable && (div_cnt_reg == DIV_LAST);
    assign boundary = adv && (digit_idx_reg == DIGIT_LAST);

    // Nibbles beyond DIGITS count as zero so they never keep a visible digit lit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_blank
            if (gi < DIGITS) begin : g_used
                assign nib_nz[gi] = |shown_val_reg[4*gi +: 4];
            end else begin : g_unused
                assign nib_nz[gi] = 1'b0;
            end
            if (gi == 0 || BLANK_LZ == 0) begin : g_never
                assign blank_vec[gi] = 1'b0;
            end else begin : g_lz
                assign blank_vec[gi] = ~|nib_nz[7:gi];
            end
        end
    endgenerate

    assign cur_nib   = shown_val_reg[{digit_idx_reg, 2'b00} +: 4];
    assign cur_blank = blank_vec[digit_idx_reg];

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_reg   <= '0;
            digit_idx_reg <= '0;
        end else if (bus.enable) begin
            div_cnt_reg <= adv ? '0 : div_cnt_reg + 1'b1;
            if (adv) begin
                digit_idx_reg <= (digit_idx_reg == DIGIT_LAST) ? 3'd0 : digit_idx_reg + 3'd1;
            end
        end
    end

    // Commit only at a frame boundary, or immediately while dark since nothing is visible to tear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shown_val_reg <= '0;
            pend_val_reg  <= '0;
            pending_reg   <= 1'b0;
        end else if (boundary && bus.load) begin
            shown_val_reg <= bus.data_in;
            pending_reg   <= 1'b0;
        end else begin
            if ((boundary || !bus.enable) && pending_reg) begin
                shown_val_reg <= pend_val_reg;
                pending_reg   <= 1'b0;
            end
            if (bus.load) begin
                pend_val_reg <= bus.data_in;
                pending_reg  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_reg <= 8'hFF;
            led_reg   <= 7'h7F;
            dp_reg    <= 1'b1;
        end else if (!bus.enable || cur_blank) begin
            anode_reg <= 8'hFF;
            led_reg   <= 7'h7F;
            dp_reg    <= 1'b1;
        end else begin
            anode_reg <= ~(8'h80 >> digit_idx_reg);
            led_reg   <= hex7(cur_nib);
            dp_reg    <= ~bus.dp_in[digit_idx_reg];
        end
    end

    assign bus.pending        = pending_reg;
    assign bus.frame_tick     = boundary;
    assign bus.Anode_Activate = anode_reg;
    assign bus.LED_out        = led_reg;
    assign bus.seg_dp         = dp_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances (blanking off/on) share the same stimulus,
// DIV_MAX=4 and DIGITS=8, so a digit slot is 4 cycles and a frame is 32 cycles.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = '0;
    logic        load = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  dp_in = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    seg7_scan_driver_if bus0 ();
    seg7_scan_driver_if bus1 ();

    assign bus0.data_in = data_in;
    assign bus0.load    = load;
    assign bus0.enable  = enable;
    assign bus0.dp_in   = dp_in;
    assign bus1.data_in = data_in;
    assign bus1.load    = load;
    assign bus1.enable  = enable;
    assign bus1.dp_in   = dp_in;

    seg7_scan_driver #(.DIV_MAX(4), .DIGITS(8), .BLANK_LZ(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    seg7_scan_driver #(.DIV_MAX(4), .DIGITS(8), .BLANK_LZ(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_tick(input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            if (bus0.frame_tick === 1'b1) found = 1'b1;
        end
        if (!found) check("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_anode", bus0.Anode_Activate, 8'hFF);
        check("rst_led", bus0.LED_out, 7'h7F);
        check("rst_dp", bus0.seg_dp, 1'b1);
        check("rst_pending", bus0.pending, 1'b0);
        check("rst_tick", bus0.frame_tick, 1'b0);
        rst = 1'b1;
        cyc = 0;

        // Free scan, first slot and digit period
        step(1);
        check("c1_anode", bus0.Anode_Activate, 8'h7F);
        check("c1_led", bus0.LED_out, 7'b0000001);
        step(3);
        check("c4_anode", bus0.Anode_Activate, 8'h7F);
        step(1);
        check("c5_anode", bus0.Anode_Activate, 8'hBF);
        wait_tick(64);
        check("tick1_cyc", cyc, 31);
        step(1);
        check("tick_one_cycle", bus0.frame_tick, 1'b0);
        wait_tick(64);
        check("tick2_cyc", cyc, 63);

        // Mid-frame load held until boundary
        step(14);
        data_in = 32'h1234ABCD;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("ld_pending", bus0.pending, 1'b1);
        check("ld_d3_anode", bus0.Anode_Activate, 8'hEF);
        check("ld_d3_old", bus0.LED_out, 7'b0000001);
        wait_tick(64);
        check("tick3_cyc", cyc, 95);
        check("pend_at_tick", bus0.pending, 1'b1);
        step(1);
        check("pend_cleared", bus0.pending, 1'b0);
        step(1);
        check("new_d0_led", bus0.LED_out, 7'b1000010);
        step(16);
        check("new_d4_anode", bus0.Anode_Activate, 8'hF7);
        check("new_d4_led", bus0.LED_out, 7'b1001100);
        step(12);
        check("new_d7_anode", bus0.Anode_Activate, 8'hFE);
        check("new_d7_led", bus0.LED_out, 7'b1001111);

        // Leading-zero blanking with 0xA5
        data_in = 32'h000000A5;
        load = 1'b1;
        step(1);
        load = 1'b0;
        wait_tick(64);
        check("tick4_cyc", cyc, 127);
        step(2);
        check("lz_d0_anode", bus1.Anode_Activate, 8'h7F);
        check("lz_d0_led", bus1.LED_out, 7'b0100100);
        step(4);
        check("lz_d1_anode", bus1.Anode_Activate, 8'hBF);
        check("lz_d1_led", bus1.LED_out, 7'b0001000);
        for (int d = 2; d < 8; d++) begin
            step(4);
            check($sformatf("lz_d%0d_dark", d), bus1.Anode_Activate, 8'hFF);
            if (d == 2) begin
                check("nolz_d2_anode", bus0.Anode_Activate, 8'hDF);
                check("nolz_d2_led", bus0.LED_out, 7'b0000001);
                check("lz_d2_led", bus1.LED_out, 7'h7F);
            end
        end

        // Zero shows a single digit
        data_in = 32'h0;
        load = 1'b1;
        step(1);
        load = 1'b0;
        wait_tick(64);
        check("tick5_cyc", cyc, 159);
        step(2);
        check("z_d0_anode", bus1.Anode_Activate, 8'h7F);
        check("z_d0_led", bus1.LED_out, 7'b0000001);
        step(4);
        check("z_d1_anode", bus1.Anode_Activate, 8'hFF);

        // Last load before the boundary wins
        data_in = 32'h11111111;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        data_in = 32'h22222222;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("multi_pending", bus0.pending, 1'b1);
        wait_tick(64);
        check("tick6_cyc", cyc, 191);
        step(2);
        for (int d = 0; d < 8; d++) begin
            if (d > 0) step(4);
            check($sformatf("two_d%0d_led", d), bus0.LED_out, 7'b0010010);
        end
        check("two_d7_anode", bus0.Anode_Activate, 8'hFE);

        // Load on the boundary cycle bypasses
        wait_tick(64);
        check("tick7_cyc", cyc, 223);
        data_in = 32'hFFFFFFFF;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("byp_pending", bus0.pending, 1'b0);
        step(1);
        check("byp_d0_anode", bus0.Anode_Activate, 8'h7F);
        check("byp_d0_led", bus0.LED_out, 7'b0111000);

        // Disable mid-scan with a load
        step(9);
        enable = 1'b0;
        data_in = 32'h5;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("dis_anode", bus0.Anode_Activate, 8'hFF);
        check("dis_led", bus0.LED_out, 7'h7F);
        check("dis_dp", bus0.seg_dp, 1'b1);
        check("dis_pend_set", bus0.pending, 1'b1);
        step(1);
        check("dis_pend_clr", bus0.pending, 1'b0);
        step(3);
        enable = 1'b1;
        step(1);
        check("resume_anode", bus0.Anode_Activate, 8'hDF);
        check("resume_led", bus0.LED_out, 7'b0000001);
        check("resume_lz_anode", bus1.Anode_Activate, 8'hFF);
        step(2);
        check("resume_d3_anode", bus0.Anode_Activate, 8'hEF);
        wait_tick(64);
        check("tick8_cyc", cyc, 260);
        dp_in = 8'h01;
        step(2);
        check("five_d0_led", bus0.LED_out, 7'b0100100);
        check("five_d0_lz_led", bus1.LED_out, 7'b0100100);
        check("dp_d0", bus0.seg_dp, 1'b0);
        step(4);
        check("dp_d1", bus0.seg_dp, 1'b1);
        check("five_d1_anode", bus0.Anode_Activate, 8'hBF);

        // Asynchronous reset mid-frame drops the pending value
        data_in = 32'h8;
        load = 1'b1;
        step(1);
        load = 1'b0;
        check("pre_rst_pending", bus0.pending, 1'b1);
        rst = 1'b0;
        #2;
        check("arst_anode", bus0.Anode_Activate, 8'hFF);
        check("arst_led", bus0.LED_out, 7'h7F);
        check("arst_dp", bus0.seg_dp, 1'b1);
        check("arst_pending", bus0.pending, 1'b0);
        step(1);
        rst = 1'b1;
        cyc = 0;
        step(1);
        check("rel_anode", bus0.Anode_Activate, 8'h7F);
        check("rel_led", bus0.LED_out, 7'b0000001);
        check("rel_pending", bus0.pending, 1'b0);
        wait_tick(64);
        check("rel_tick_cyc", cyc, 31);
        step(2);
        check("rel_lost_led", bus0.LED_out, 7'b0000001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
